// File: rtl/fir_job_sequencer_if.sv
// Bus bundle between the job sequencer and the fir_lab4 engine:
// AXI-lite write/read channels plus the X (ss) and Y (sm) AXI-stream channels.
interface fir_job_sequencer_if #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;
    logic                   ss_tvalid;
    logic                   ss_tready;
    logic                   ss_tlast;
    logic [pDATA_WIDTH-1:0] ss_tdata;
    logic                   sm_tvalid;
    logic                   sm_tready;
    logic                   sm_tlast;
    logic [pDATA_WIDTH-1:0] sm_tdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        input  awready, wready, arready, rvalid, rdata,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
        output awready, wready, arready, rvalid, rdata,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/fir_job_sequencer.sv
// Runs one complete FIR job per command: program length and taps, start the engine,
// stream X in and Y out, then poll ap_done.
module fir_job_sequencer #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned Tape_Num    = 11,
    parameter int unsigned POLL_MAX    = 255
) (
    input  logic                            axis_clk,
    input  logic                            axis_rst_n,
    input  logic                            cmd_start,
    input  logic [pDATA_WIDTH-1:0]          cmd_len,
    input  logic [Tape_Num*pDATA_WIDTH-1:0] cmd_taps,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    fir_job_sequencer_if.master             fir,
    input  logic                            x_valid,
    output logic                            x_ready,
    input  logic [pDATA_WIDTH-1:0]          x_data,
    output logic                            y_valid,
    input  logic                            y_ready,
    output logic [pDATA_WIDTH-1:0]          y_data,
    output logic                            y_last
);
    localparam int unsigned TapW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
    localparam logic [pADDR_WIDTH-1:0] AddrCtrl = 'h00;
    localparam logic [pADDR_WIDTH-1:0] AddrLen  = 'h10;
    localparam logic [pADDR_WIDTH-1:0] AddrTap  = 'h40;

    typedef enum logic [2:0] {
        StIdle, StWrLen, StWrTap, StWrStart, StStream, StPoll, StDone
    } state_e;

    state_e                          state_q, state_d;
    logic [pDATA_WIDTH-1:0]          len_q, len_d;
    logic [Tape_Num*pDATA_WIDTH-1:0] taps_q, taps_d;
    logic [TapW-1:0]                 tap_idx_q, tap_idx_d;
    logic                            aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
    logic [31:0]                     x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [31:0]                     poll_cnt_q, poll_cnt_d;
    logic                            rd_wait_q, rd_wait_d;
    logic                            err_q, err_d;

    logic wr_state, aw_hs, w_hs, wr_done, x_open, y_open, x_hs, y_hs;
    logic unused_rdata;

    // Only ap_done is consumed from the status word.
    assign unused_rdata = ^{fir.rdata[pDATA_WIDTH-1:2], fir.rdata[0]};

    always_comb begin
        wr_state = (state_q == StWrLen) || (state_q == StWrTap) || (state_q == StWrStart);
        x_open   = (state_q == StStream) && (x_cnt_q < len_q);
        y_open   = (state_q == StStream) && (y_cnt_q < len_q);

        fir.awvalid   = wr_state && !aw_ok_q;
        fir.wvalid    = wr_state && !w_ok_q;
        fir.awaddr    = '0;
        fir.wdata     = '0;
        case (state_q)
            StWrLen: begin
                fir.awaddr = AddrLen;
                fir.wdata  = len_q;
            end
            StWrTap: begin
                fir.awaddr = AddrTap + pADDR_WIDTH'({tap_idx_q, 2'b00});
                fir.wdata  = taps_q[tap_idx_q*pDATA_WIDTH +: pDATA_WIDTH];
            end
            StWrStart: begin
                fir.awaddr = AddrCtrl;
                fir.wdata  = pDATA_WIDTH'(1);
            end
            default: ;
        endcase

        fir.arvalid   = (state_q == StPoll) && !rd_wait_q;
        fir.rready    = (state_q == StPoll) && rd_wait_q;
        fir.araddr    = AddrCtrl;

        fir.ss_tvalid = x_valid && x_open;
        fir.ss_tdata  = x_data;
        fir.ss_tlast  = (state_q == StStream) && (x_cnt_q == len_q - 1'b1);
        x_ready       = fir.ss_tready && x_open;

        y_valid       = fir.sm_tvalid && y_open;
        fir.sm_tready = y_ready && y_open;
        y_data        = fir.sm_tdata;
        y_last        = fir.sm_tlast;

        aw_hs   = fir.awvalid && fir.awready;
        w_hs    = fir.wvalid && fir.wready;
        wr_done = (aw_ok_q || aw_hs) && (w_ok_q || w_hs);
        x_hs    = fir.ss_tvalid && fir.ss_tready;
        y_hs    = fir.sm_tvalid && fir.sm_tready;

        busy = (state_q != StIdle) && (state_q != StDone);
        done = (state_q == StDone);
        err  = err_q;
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        taps_d     = taps_q;
        tap_idx_d  = tap_idx_q;
        aw_ok_d    = aw_ok_q;
        w_ok_d     = w_ok_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        poll_cnt_d = poll_cnt_q;
        rd_wait_d  = rd_wait_q;
        err_d      = err_q;

        // Address and data phases may complete in different cycles; remember which is done.
        if (wr_state) begin
            aw_ok_d = wr_done ? 1'b0 : (aw_ok_q || aw_hs);
            w_ok_d  = wr_done ? 1'b0 : (w_ok_q || w_hs);
        end

        case (state_q)
            StIdle: begin
                if (cmd_start) begin
                    len_d      = cmd_len;
                    taps_d     = cmd_taps;
                    tap_idx_d  = '0;
                    x_cnt_d    = '0;
                    y_cnt_d    = '0;
                    poll_cnt_d = '0;
                    rd_wait_d  = 1'b0;
                    err_d      = (cmd_len == '0);
                    state_d    = (cmd_len == '0) ? StDone : StWrLen;
                end
            end
            StWrLen: if (wr_done) state_d = StWrTap;
            StWrTap: begin
                if (wr_done) begin
                    if (tap_idx_q == TapW'(Tape_Num - 1)) state_d = StWrStart;
                    else tap_idx_d = tap_idx_q + 1'b1;
                end
            end
            StWrStart: if (wr_done) state_d = StStream;
            StStream: begin
                if (x_hs) x_cnt_d = x_cnt_q + 1;
                if (y_hs) begin
                    y_cnt_d = y_cnt_q + 1;
                    if (fir.sm_tlast != (y_cnt_q == len_q - 1'b1)) err_d = 1'b1;
                end
                if ((x_cnt_d == len_q) && (y_cnt_d == len_q)) state_d = StPoll;
            end
            StPoll: begin
                if (!rd_wait_q) begin
                    if (fir.arready) rd_wait_d = 1'b1;
                end else if (fir.rvalid) begin
                    rd_wait_d  = 1'b0;
                    poll_cnt_d = poll_cnt_q + 1;
                    if (fir.rdata[1]) begin
                        state_d = StDone;
                    end else if (poll_cnt_d >= POLL_MAX) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            taps_q     <= '0;
            tap_idx_q  <= '0;
            aw_ok_q    <= 1'b0;
            w_ok_q     <= 1'b0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            poll_cnt_q <= '0;
            rd_wait_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            taps_q     <= taps_d;
            tap_idx_q  <= tap_idx_d;
            aw_ok_q    <= aw_ok_d;
            w_ok_q     <= w_ok_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            rd_wait_q  <= rd_wait_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_fir_job_sequencer.sv
// Bench for fir_job_sequencer: a small behavioural FIR engine on the bus side,
// directed jobs on the user side, Y results checked against a reference convolution.
module tb_fir_job_sequencer;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned NT = 11;
    localparam int unsigned PM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             cmd_start;
    logic [DW-1:0]    cmd_len;
    logic [NT*DW-1:0] cmd_taps;
    logic             busy, done, err;
    logic             x_valid, x_ready, y_valid, y_ready, y_last;
    logic [DW-1:0]    x_data, y_data;

    fir_job_sequencer_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    fir_job_sequencer #(
        .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT), .POLL_MAX(PM)
    ) dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .cmd_start(cmd_start), .cmd_len(cmd_len),
        .cmd_taps(cmd_taps), .busy(busy), .done(done), .err(err), .fir(bus),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last)
    );

    // ---------------- behavioural FIR engine ----------------
    int            aw_lag, aw_wait, rd_count, aw_cycles, y_wp, y_rp;
    bit            never_done;
    logic          aw_hold, w_hold, m_started, ap_done, rd_pend, commit, aw_now, w_now;
    logic [AW-1:0] aw_addr_h, c_addr;
    logic [DW-1:0] w_data_h, c_data, m_len;
    logic [DW-1:0] m_taps [NT];
    logic [DW-1:0] hist [NT];
    logic [DW-1:0] y_buf [256];
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];

    assign bus.awready   = bus.awvalid && (aw_wait >= aw_lag);
    assign bus.wready    = 1'b1;
    assign bus.arready   = 1'b1;
    assign bus.rvalid    = rd_pend;
    assign bus.rdata     = {30'd0, ap_done, 1'b0};
    assign bus.ss_tready = m_started;
    assign bus.sm_tvalid = (y_wp != y_rp);
    assign bus.sm_tdata  = y_buf[y_rp[7:0]];
    assign bus.sm_tlast  = (y_rp == int'(m_len) - 1);

    always_comb begin
        aw_now = bus.awvalid && bus.awready;
        w_now  = bus.wvalid && bus.wready;
        commit = (aw_hold || aw_now) && (w_hold || w_now);
        c_addr = aw_now ? bus.awaddr : aw_addr_h;
        c_data = w_now ? bus.wdata : w_data_h;
    end

    function automatic logic [DW-1:0] fir_out(input logic [DW-1:0] x);
        logic [DW-1:0] acc = m_taps[0] * x;
        for (int k = 1; k < NT; k++) acc += m_taps[k] * hist[k-1];
        return acc;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; aw_hold <= 1'b0; w_hold <= 1'b0; aw_addr_h <= '0; w_data_h <= '0;
            m_started <= 1'b0; ap_done <= 1'b0; rd_pend <= 1'b0; rd_count <= 0;
            m_len <= '0; y_wp <= 0; y_rp <= 0; aw_cycles <= 0;
            for (int k = 0; k < NT; k++) begin
                m_taps[k] <= '0;
                hist[k]   <= '0;
            end
        end else begin
            if (bus.awvalid) aw_cycles <= aw_cycles + 1;
            if (bus.awvalid && !bus.awready) aw_wait <= aw_wait + 1;
            else aw_wait <= 0;
            if (commit) begin
                aw_hold <= 1'b0;
                w_hold  <= 1'b0;
                wr_addr_log.push_back(c_addr);
                wr_data_log.push_back(c_data);
                if (c_addr == 12'h010) m_len <= c_data;
                else if (c_addr >= 12'h040 && c_addr < 12'h040 + 12'(4 * NT))
                    m_taps[int'((c_addr - 12'h040) >> 2)] <= c_data;
                else if (c_addr == 12'h000 && c_data[0]) begin
                    m_started <= 1'b1; ap_done <= 1'b0; y_wp <= 0; y_rp <= 0; rd_count <= 0;
                    for (int k = 0; k < NT; k++) hist[k] <= '0;
                end
            end else begin
                if (aw_now) begin aw_hold <= 1'b1; aw_addr_h <= bus.awaddr; end
                if (w_now) begin w_hold <= 1'b1; w_data_h <= bus.wdata; end
            end
            if (bus.ss_tvalid && bus.ss_tready) begin
                hist[0] <= bus.ss_tdata;
                for (int k = 1; k < NT; k++) hist[k] <= hist[k-1];
                y_buf[y_wp[7:0]] <= fir_out(bus.ss_tdata);
                y_wp <= y_wp + 1;
            end
            if (bus.sm_tvalid && bus.sm_tready) begin
                y_rp <= y_rp + 1;
                if (y_rp == int'(m_len) - 1 && !never_done) begin
                    ap_done   <= 1'b1;
                    m_started <= 1'b0;
                end
            end
            if (bus.arvalid && bus.arready) begin
                rd_pend  <= 1'b1;
                rd_count <= rd_count + 1;
            end else if (rd_pend && bus.rready) rd_pend <= 1'b0;
        end
    end

    // ---------------- checking helpers ----------------
    int            n_checks = 0;
    int            n_err    = 0;
    logic [DW-1:0] y_exp [$];
    logic [DW-1:0] taps_in [NT];
    logic [DW-1:0] xs [64];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_y(input int i);
        logic [DW-1:0] acc = '0;
        for (int k = 0; k < NT; k++) if (i - k >= 0) acc += taps_in[k] * xs[i-k];
        return acc;
    endfunction

    task automatic start_cmd(input int len);
        @(negedge clk);
        cmd_len = DW'(len);
        for (int k = 0; k < NT; k++) cmd_taps[k*DW +: DW] = taps_in[k];
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic drive_x(input int n, input bit gaps, input int stop_at);
        int i = 0;
        int guard = 0;
        bit hs;
        while (i < n && i != stop_at && guard < 4000) begin
            @(negedge clk);
            x_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            x_data  = xs[i];
            #2;
            hs = x_valid && x_ready;
            if (hs) begin
                check("ss_tlast", DW'(bus.ss_tlast), DW'(i == n - 1));
                check("ss_tdata", bus.ss_tdata, xs[i]);
                y_exp.push_back(ref_y(i));
            end
            @(posedge clk);
            if (hs) i++;
            guard++;
        end
        if (i != n && i != stop_at) check("x_count", DW'(i), DW'(n));
        if (i != stop_at) begin
            #1;
            x_valid = 1'b0;
        end
    endtask

    task automatic sink_y(input int n, input bit gaps);
        int got = 0;
        int guard = 0;
        bit hs;
        while (got < n && guard < 4000) begin
            @(negedge clk);
            y_ready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            hs = y_valid && y_ready;
            if (hs) begin
                if (y_exp.size() == 0) check("y_queue", DW'(y_exp.size()), 1);
                else check("y_data", y_data, y_exp.pop_front());
                check("y_last", DW'(y_last), DW'(got == n - 1));
            end
            @(posedge clk);
            if (hs) got++;
            guard++;
        end
        check("y_count", DW'(got), DW'(n));
        #1;
        y_ready = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err, input string tag);
        int guard = 0;
        while (done !== 1'b1 && guard < 6000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done"}, DW'(done), 1);
        check({tag, "_err"}, DW'(err), DW'(exp_err));
        check({tag, "_busy_at_done"}, DW'(busy), 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, DW'(done), 0);
        check({tag, "_err_held"}, DW'(err), DW'(exp_err));
    endtask

    task automatic check_writes(input int base, input int len, input string tag);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        check({tag, "_nwrites"}, DW'(wr_addr_log.size() - base), DW'(NT + 2));
        if (wr_addr_log.size() - base == NT + 2) begin
            for (int j = 0; j < NT + 2; j++) begin
                if (j == 0) begin ea = 12'h010; ed = DW'(len); end
                else if (j <= NT) begin ea = 12'h040 + 12'(4 * (j - 1)); ed = taps_in[j-1]; end
                else begin ea = 12'h000; ed = 32'h1; end
                check({tag, "_waddr"}, DW'(wr_addr_log[base+j]), DW'(ea));
                check({tag, "_wdata"}, wr_data_log[base+j], ed);
            end
        end
    endtask

    task automatic run_job(input int len, input bit gaps, input int lag, input bit nd,
                           input bit exp_err, input int exp_reads, input string tag);
        int base;
        aw_lag     = lag;
        never_done = nd;
        base       = wr_addr_log.size();
        start_cmd(len);
        check({tag, "_busy"}, DW'(busy), 1);
        fork
            drive_x(len, gaps, -1);
            sink_y(len, gaps);
            wait_done(exp_err, tag);
        join
        check_writes(base, len, tag);
        check({tag, "_reads"}, DW'(rd_count), DW'(exp_reads));
        check({tag, "_y_left"}, DW'(y_exp.size()), 0);
    endtask

    task automatic setup_t1();
        for (int k = 0; k < NT; k++) taps_in[k] = DW'(k + 1);
        for (int i = 0; i < 4; i++) xs[i] = DW'(i + 1);
    endtask

    // ---------------- directed sequence ----------------
    int aw_before;

    initial begin
        rst_n = 1'b0; cmd_start = 1'b0; cmd_len = '0; cmd_taps = '0;
        x_valid = 1'b0; x_data = '0; y_ready = 1'b0; aw_lag = 0; never_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", DW'({busy, done, err, bus.awvalid, bus.wvalid, bus.arvalid,
              bus.rready, bus.ss_tvalid, bus.ss_tlast, bus.sm_tready, x_ready, y_valid}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", DW'(busy), 0);

        // T1: basic 4-sample job; expected Y = 1, 4, 10, 20
        setup_t1();
        check("t1_ref_y3", ref_y(3), 32'd20);
        run_job(4, 1'b0, 0, 1'b0, 1'b0, 1, "t1");

        // T2: awready lags wready by 3 cycles
        run_job(4, 1'b0, 3, 1'b0, 1'b0, 1, "t2");

        // T3: 64 samples with random source/sink gaps
        for (int i = 0; i < 64; i++) xs[i] = DW'($urandom_range(0, 1000));
        run_job(64, 1'b1, 0, 1'b0, 1'b0, 1, "t3");

        // T4: zero length finishes with error and never touches the FIR
        aw_before = aw_cycles;
        start_cmd(0);
        check("t4_done", DW'(done), 1);
        check("t4_err", DW'(err), 1);
        check("t4_busy", DW'(busy), 0);
        @(negedge clk);
        check("t4_done_pulse", DW'(done), 0);
        check("t4_err_held", DW'(err), 1);
        check("t4_no_aw", DW'(aw_cycles - aw_before), 0);

        // T5: engine never reports ap_done
        setup_t1();
        run_job(4, 1'b0, 0, 1'b1, 1'b1, PM, "t5");

        // T6: reset in the middle of a stream, then a clean job
        never_done = 1'b0;
        aw_lag     = 0;
        for (int i = 0; i < 64; i++) xs[i] = DW'(i + 7);
        start_cmd(64);
        y_ready = 1'b1;
        drive_x(64, 1'b0, 10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_reset_outputs", DW'({busy, done, err, bus.awvalid, bus.wvalid, bus.arvalid,
              bus.rready, bus.ss_tvalid, bus.ss_tlast, bus.sm_tready, x_ready, y_valid}), 0);
        x_valid = 1'b0;
        y_ready = 1'b0;
        y_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        setup_t1();
        run_job(4, 1'b0, 0, 1'b0, 1'b0, 1, "t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
